pace_generator: RTL
===================

PACE_GENERATOR -- requirements
Module: pace_generator

Interface
REQ-001 Parameter PULSE_CYC, default 2: pace pulse width in clk_2 cycles (legal range 1..15).
REQ-002 Parameter REF_CYC, default 3: refractory length in clk_2 cycles (legal range 1..15).
REQ-003 Port clk_2  input  1  system clock; all state updates occur on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port enable  input  1  pacing enabled when high.
REQ-006 Port sense  input  1  natural-beat indication, synchronous to clk_2, level sampled each cycle.
REQ-007 Port interval  input  8  escape interval in cycles; a value of 0 is treated as 1.
REQ-008 Port pace  output  1  stimulus pulse, registered.
REQ-009 Port sense_evt  output  1  one-cycle registered flag for an accepted natural beat.
REQ-010 Port refractory  output  1  high while in REFRACT.
REQ-011 Port pace_count  output  8  number of pace pulses issued, saturating at 255.

Function
REQ-012 The FSM SHALL have exactly four states: IDLE, WAIT, PACE, REFRACT.
REQ-013 An 8-bit cycle counter cnt SHALL be cleared on every state transition.
REQ-014 The escape value esc SHALL be latched as max(interval,1) on each entry to WAIT; interval changes during WAIT SHALL have no effect until the next WAIT entry.
REQ-015 IDLE: if enable=1 -> WAIT next cycle; otherwise remain.
REQ-016 WAIT, sense=1 -> REFRACT next cycle, with sense_evt=1 for exactly that cycle.
REQ-017 WAIT, sense=0 and cnt==esc-1 -> PACE next cycle; otherwise cnt increments.
REQ-018 Pace timing: the first pace cycle SHALL occur esc cycles after the first WAIT cycle.
REQ-019 Simultaneous sense=1 and expiry (cnt==esc-1) SHALL resolve in favour of sense: no pace is issued, and the FSM enters REFRACT.
REQ-020 PACE: pace=1 for exactly PULSE_CYC consecutive cycles, then REFRACT; sense SHALL be ignored.
REQ-021 On each PACE entry, pace_count SHALL increment by 1 if below 255; at 255 it SHALL hold.
REQ-022 REFRACT: refractory=1 for exactly REF_CYC cycles, then WAIT; sense SHALL be ignored and SHALL not raise sense_evt.
REQ-023 enable=0 in any state -> IDLE next cycle, with pace, refractory and sense_evt low from that cycle.
REQ-024 An aborted pulse on enable=0 SHALL still have counted in pace_count.
REQ-025 pace, refractory and sense_evt SHALL be decoded from registered state and never combinationally from inputs.
REQ-026 At most one of pace and refractory SHALL be high in any cycle.
REQ-027 sense_evt SHALL never be high for two consecutive cycles.

Reset
REQ-028 reset=1 SHALL immediately force state=IDLE, cnt=0, esc=1, pace=0, sense_evt=0, refractory=0 and pace_count=0, regardless of clk_2.
REQ-029 Reset asserted mid-pulse SHALL drop pace asynchronously.
REQ-030 After reset deasserts with enable=1, WAIT SHALL be entered on the first clk_2 rising edge.

Verification
REQ-031 Scenario: enable=1, interval=5, sense=0 -> pace high for 2 cycles starting 5 cycles after WAIT entry, then refractory for 3 cycles; the period repeats every 10 cycles and pace_count=3 after 3 periods.
REQ-032 Scenario: interval=5, sense pulse in the 3rd WAIT cycle -> sense_evt for 1 cycle, no pace, REFRACT 3 cycles, and the escape timer restarts.
REQ-033 Scenario: sense=1 exactly on the expiry cycle (cnt=4, interval=5) -> no pace, sense_evt=1, and pace_count is unchanged.
REQ-034 Scenario: sense held high throughout PACE and REFRACT -> no sense_evt in those states, and sense_evt=1 on the first WAIT cycle's transition.
REQ-035 Scenario: interval=0 -> pace pulses every 1+2+3=6 cycles; and interval=255 with 260 pulses -> pace_count saturates at 255.
REQ-036 Scenario: reset asserted mid-PACE, or enable dropped mid-PACE -> pace=0 immediately (on reset) or in the next cycle (on enable), and the FSM is in IDLE.

Source files
------------

// File: rtl/pace_generator.sv
// Demand pacemaker timing core: escape-interval timer with natural-beat inhibit,
// fixed-width pace pulse and refractory blanking, all outputs registered.
module pace_generator #(
    parameter int unsigned PULSE_CYC = 2,
    parameter int unsigned REF_CYC   = 3
) (
    input  logic       clk_2,
    input  logic       reset,
    input  logic       enable,
    input  logic       sense,
    input  logic [7:0] interval,
    output logic       pace,
    output logic       sense_evt,
    output logic       refractory,
    output logic [7:0] pace_count
);

    typedef enum logic [1:0] {IDLE, WAIT, PACE, REFRACT} state_t;

    localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYC - 1);
    localparam logic [7:0] REF_LAST   = 8'(REF_CYC - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] esc_q, esc_d;
    logic [7:0] count_q, count_d;
    logic       evt_d;

    // Next-state logic; a sense beat on the expiry cycle wins over pacing.
    always_comb begin
        state_d = state_q;
        cnt_d   = (state_q == IDLE) ? cnt_q : cnt_q + 8'd1;
        esc_d   = esc_q;
        count_d = count_q;
        evt_d   = 1'b0;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = WAIT;
                WAIT: begin
                    if (sense) begin
                        state_d = REFRACT;
                        evt_d   = 1'b1;
                    end else if (cnt_q == esc_q - 8'd1) begin
                        state_d = PACE;
                    end
                end
                PACE:    if (cnt_q == PULSE_LAST) state_d = REFRACT;
                REFRACT: if (cnt_q == REF_LAST) state_d = WAIT;
                default: state_d = IDLE;
            endcase
        end
        if (state_d != state_q) begin
            cnt_d = 8'd0;
        end
        // Escape interval is frozen for the whole WAIT period.
        if (state_d == WAIT && state_q != WAIT) begin
            esc_d = (interval == 8'd0) ? 8'd1 : interval;
        end
        if (state_d == PACE && state_q != PACE && count_q != 8'hFF) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            esc_q      <= 8'd1;
            count_q    <= 8'd0;
            pace       <= 1'b0;
            refractory <= 1'b0;
            sense_evt  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            esc_q      <= esc_d;
            count_q    <= count_d;
            pace       <= (state_d == PACE);
            refractory <= (state_d == REFRACT);
            sense_evt  <= evt_d;
        end
    end

    assign pace_count = count_q;

endmodule
